// File: rtl/line_drawer.sv
// Bresenham line rasteriser covering all octants, endpoints inclusive.
// Emits one pixel per accepted transfer on a valid/ready stream.
module line_drawer #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [Y_WIDTH-1:0] y2,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               pixel_valid,
  input  logic               pixel_ready
);

  localparam int W =
    ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
  localparam logic [X_WIDTH-1:0] X_ONE = 1;
  localparam logic [Y_WIDTH-1:0] Y_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DRAW = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [X_WIDTH-1:0] cur_x, cur_x_nxt;
  logic [Y_WIDTH-1:0] cur_y, cur_y_nxt;
  logic [X_WIDTH-1:0] end_x, end_x_nxt;
  logic [Y_WIDTH-1:0] end_y, end_y_nxt;
  logic signed [W-1:0] dx, dx_nxt;
  logic signed [W-1:0] dy, dy_nxt;
  logic signed [W-1:0] err, err_nxt;
  logic signed [W-1:0] e2;
  logic signed [W-1:0] xa, xb, ya, yb;
  logic sx, sx_nxt;
  logic sy, sy_nxt;

  // sx/sy set means step in the negative direction
  assign xa = signed'({{(W-X_WIDTH){1'b0}}, cur_x});
  assign xb = signed'({{(W-X_WIDTH){1'b0}}, end_x});
  assign ya = signed'({{(W-Y_WIDTH){1'b0}}, cur_y});
  assign yb = signed'({{(W-Y_WIDTH){1'b0}}, end_y});
  assign e2 = err + err;

  assign ready       = (state == IDLE);
  assign pixel_valid = (state == DRAW);
  assign pixel_x     = cur_x;
  assign pixel_y     = cur_y;

  always_comb begin
    state_nxt = state;
    cur_x_nxt = cur_x;
    cur_y_nxt = cur_y;
    end_x_nxt = end_x;
    end_y_nxt = end_y;
    dx_nxt    = dx;
    dy_nxt    = dy;
    err_nxt   = err;
    sx_nxt    = sx;
    sy_nxt    = sy;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = INIT;
          cur_x_nxt = x1;
          cur_y_nxt = y1;
          end_x_nxt = x2;
          end_y_nxt = y2;
        end
      end
      INIT: begin
        dx_nxt    = (xa < xb) ? (xb - xa) : (xa - xb);
        dy_nxt    = (ya < yb) ? (ya - yb) : (yb - ya);
        sx_nxt    = !(cur_x < end_x);
        sy_nxt    = !(cur_y < end_y);
        err_nxt   = dx_nxt + dy_nxt;
        state_nxt = DRAW;
      end
      DRAW: begin
        if (pixel_ready) begin
          if (cur_x == end_x && cur_y == end_y) begin
            state_nxt = IDLE;
          end else begin
            if (e2 >= dy && e2 <= dx) begin
              err_nxt = err + dy + dx;
            end else if (e2 >= dy) begin
              err_nxt = err + dy;
            end else if (e2 <= dx) begin
              err_nxt = err + dx;
            end
            if (e2 >= dy) begin
              cur_x_nxt = sx ? cur_x - X_ONE
                             : cur_x + X_ONE;
            end
            if (e2 <= dx) begin
              cur_y_nxt = sy ? cur_y - Y_ONE
                             : cur_y + Y_ONE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur_x <= '0;
      cur_y <= '0;
      end_x <= '0;
      end_y <= '0;
      dx    <= '0;
      dy    <= '0;
      err   <= '0;
      sx    <= 1'b0;
      sy    <= 1'b0;
    end else begin
      state <= state_nxt;
      cur_x <= cur_x_nxt;
      cur_y <= cur_y_nxt;
      end_x <= end_x_nxt;
      end_y <= end_y_nxt;
      dx    <= dx_nxt;
      dy    <= dy_nxt;
      err   <= err_nxt;
      sx    <= sx_nxt;
      sy    <= sy_nxt;
    end
  end

endmodule
